// File: rtl/bash_pkg.sv
// Shared types, command ids, keyword and response strings for the bash command sequencer.
package bash_pkg;

  localparam int unsigned MAX_LINE  = 32;
  localparam int unsigned CHAR_W    = 8;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned ID_W      = 3;
  localparam int unsigned TMR_W     = 8;
  localparam int unsigned ROM_CHARS = 31;
  localparam int unsigned ROM_W     = ROM_CHARS * CHAR_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FETCH_GAP,
    ST_DECODE,
    ST_EMIT,
    ST_EMIT_GAP,
    ST_SOLVE,
    ST_WAIT_ACK
  } state_t;

  localparam logic [ID_W-1:0] CMD_EMPTY   = 3'd0;
  localparam logic [ID_W-1:0] CMD_ECHO    = 3'd1;
  localparam logic [ID_W-1:0] CMD_HELLO   = 3'd2;
  localparam logic [ID_W-1:0] CMD_HELP    = 3'd3;
  localparam logic [ID_W-1:0] CMD_UNKNOWN = 3'd7;

  localparam logic [4*CHAR_W-1:0] KW_ECHO  = "echo";
  localparam logic [5*CHAR_W-1:0] KW_HELLO = "hello";
  localparam logic [4*CHAR_W-1:0] KW_HELP  = "help";

  // Echo argument starts after the keyword plus exactly one separator space.
  localparam logic [CNT_W-1:0] ECHO_SKIP = 6'd5;

  // Strings are right-aligned in the vector; LEN gives the printable length.
  localparam logic [ROM_W-1:0] RESP_HELLO   = ROM_W'("Hello World!");
  localparam logic [ROM_W-1:0] RESP_HELP    = ROM_W'("echo hello help");
  localparam logic [ROM_W-1:0] RESP_UNKNOWN = ROM_W'("Unknown command");

  localparam logic [CNT_W-1:0] RESP_HELLO_LEN   = 6'd12;
  localparam logic [CNT_W-1:0] RESP_HELP_LEN    = 6'd15;
  localparam logic [CNT_W-1:0] RESP_UNKNOWN_LEN = 6'd15;

  // Character idx (0 = leftmost) of a right-aligned string, 0 past its end.
  function automatic logic [CHAR_W-1:0] str_char(input logic [ROM_W-1:0] s,
                                                 input logic [CNT_W-1:0] len,
                                                 input logic [CNT_W-1:0] idx);
    logic [CNT_W-1:0] rem;
    logic [CNT_W+2:0] sh;
    rem = len - idx - 6'd1;
    sh  = {rem, 3'b000};
    str_char = (idx < len) ? CHAR_W'(s >> sh) : '0;
  endfunction

endpackage

// File: rtl/bash_resp_rom.sv
// Fixed response text lookup by command id and character index; 0 beyond each string.
module bash_resp_rom
  import bash_pkg::*;
(
  input  logic [ID_W-1:0]   cmd_id,
  input  logic [CNT_W-1:0]  index,
  output logic [CHAR_W-1:0] rom_char
);

  always_comb begin
    rom_char = '0;
    case (cmd_id)
      CMD_HELLO:   rom_char = str_char(RESP_HELLO, RESP_HELLO_LEN, index);
      CMD_HELP:    rom_char = str_char(RESP_HELP, RESP_HELP_LEN, index);
      CMD_UNKNOWN: rom_char = str_char(RESP_UNKNOWN, RESP_UNKNOWN_LEN, index);
      default:     rom_char = '0;
    endcase
  end

endmodule

// File: rtl/bash_cmd_sequencer.sv
// Pulls a typed line from the terminal, decodes its first word and streams the response
// back, then pulses solved and waits (bounded) for the terminal's acknowledge.
module bash_cmd_sequencer
  import bash_pkg::*;
#(
  parameter int unsigned MAX_LINE    = bash_pkg::MAX_LINE,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_ready,
  input  logic [CNT_W-1:0]  cmd_len,
  input  logic [CHAR_W-1:0] cmd_char,
  output logic              cmd_next,
  output logic              resp_ready,
  output logic [CHAR_W-1:0] resp_char,
  input  logic              resp_next,
  output logic              solved,
  input  logic              solved_ack,
  output logic              busy,
  output logic [ID_W-1:0]   cmd_id
);

  localparam int unsigned AW = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  resp_idx;
  logic [TMR_W-1:0]  timer;
  logic [CHAR_W-1:0] line_buf [MAX_LINE];

  logic              fetch_done_c;
  logic [CNT_W-1:0]  stored_len_c;
  logic [CNT_W-1:0]  word_len_c;
  logic              space_found_c;
  logic [ID_W-1:0]   dec_id_c;
  logic [ID_W-1:0]   rom_id_c;
  logic [CNT_W-1:0]  rom_idx_c;
  logic [CHAR_W-1:0] rom_char_c;
  logic [CNT_W:0]    echo_pos_c;
  logic [CHAR_W-1:0] echo_char_c;
  logic [CHAR_W-1:0] next_char_c;

  assign fetch_done_c = (cmd_char == '0) || (count == cmd_len) || !cmd_ready;
  assign stored_len_c = (32'(count) < MAX_LINE) ? count : CNT_W'(MAX_LINE);

  // Line buffer carries no reset; only the first stored_len_c entries are ever read.
  always_ff @(posedge clk) begin
    if (state == ST_FETCH && !fetch_done_c && 32'(count) < MAX_LINE) begin
      line_buf[count[AW-1:0]] <= cmd_char;
    end
  end

  // First word ends at the first space or at the end of the stored text.
  always_comb begin
    word_len_c    = stored_len_c;
    space_found_c = 1'b0;
    for (int unsigned i = 0; i < MAX_LINE; i++) begin
      if (!space_found_c && i < 32'(stored_len_c) && line_buf[AW'(i)] == 8'h20) begin
        word_len_c    = CNT_W'(i);
        space_found_c = 1'b1;
      end
    end
  end

  always_comb begin
    dec_id_c = CMD_UNKNOWN;
    if (stored_len_c == '0) begin
      dec_id_c = CMD_EMPTY;
    end else if (word_len_c == 6'd4 &&
                 {line_buf[0], line_buf[1], line_buf[2], line_buf[3]} == KW_ECHO) begin
      dec_id_c = CMD_ECHO;
    end else if (word_len_c == 6'd5 &&
                 {line_buf[0], line_buf[1], line_buf[2], line_buf[3], line_buf[4]} == KW_HELLO) begin
      dec_id_c = CMD_HELLO;
    end else if (word_len_c == 6'd4 &&
                 {line_buf[0], line_buf[1], line_buf[2], line_buf[3]} == KW_HELP) begin
      dec_id_c = CMD_HELP;
    end
  end

  // During DECODE the first response char is looked up from the not-yet-registered id.
  assign rom_id_c  = (state == ST_DECODE) ? dec_id_c : cmd_id;
  assign rom_idx_c = (state == ST_DECODE) ? '0 : resp_idx;

  bash_resp_rom u_rom (
    .cmd_id   (rom_id_c),
    .index    (rom_idx_c),
    .rom_char (rom_char_c)
  );

  assign echo_pos_c  = {1'b0, rom_idx_c} + {1'b0, ECHO_SKIP};
  assign echo_char_c = (echo_pos_c < {1'b0, stored_len_c}) ? line_buf[echo_pos_c[AW-1:0]] : '0;
  assign next_char_c = (rom_id_c == CMD_ECHO) ? echo_char_c : rom_char_c;

  // Sequencer FSM with registered outputs; cmd_next and solved are single-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      count      <= '0;
      resp_idx   <= '0;
      timer      <= '0;
      cmd_next   <= 1'b0;
      resp_ready <= 1'b0;
      resp_char  <= '0;
      solved     <= 1'b0;
      busy       <= 1'b0;
      cmd_id     <= CMD_EMPTY;
    end else begin
      cmd_next <= 1'b0;
      solved   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_ready) begin
            count <= '0;
            busy  <= 1'b1;
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (fetch_done_c) begin
            state <= ST_DECODE;
          end else begin
            if (count != '1) count <= count + 6'd1;
            cmd_next <= 1'b1;
            state    <= ST_FETCH_GAP;
          end
        end
        ST_FETCH_GAP: state <= ST_FETCH;
        ST_DECODE: begin
          cmd_id   <= dec_id_c;
          resp_idx <= '0;
          if (dec_id_c == CMD_EMPTY) begin
            solved <= 1'b1;
            state  <= ST_SOLVE;
          end else begin
            resp_ready <= 1'b1;
            resp_char  <= next_char_c;
            state      <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (resp_next) begin
            resp_ready <= 1'b0;
            if (resp_char == '0) begin
              solved <= 1'b1;
              state  <= ST_SOLVE;
            end else begin
              resp_idx <= resp_idx + 6'd1;
              state    <= ST_EMIT_GAP;
            end
          end
        end
        ST_EMIT_GAP: begin
          resp_ready <= 1'b1;
          resp_char  <= next_char_c;
          state      <= ST_EMIT;
        end
        ST_SOLVE: begin
          // SOLVE plus WAIT_ACK together last ACK_TIMEOUT cycles without an ack.
          timer <= TMR_W'(ACK_TIMEOUT - 1);
          state <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (solved_ack || timer <= 8'd1) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
